// File: rtl/irq_arbiter.sv
// irq_arbiter: NSRC edge-captured interrupt sources issued one at a time as a CPU irq pulse; define IRQ_ARBITER_RR_EN for round-robin.
// Latency: source edge to irq pulse 2 cycles; register ack 1 cycle after request.
// Backpressure: no new issue until the eoi high/low handshake completes or EOI_TIMEOUT expires; register port has no wait states.
module irq_arbiter #(
   parameter int NSRC        = 8,
   parameter int IRQ_BASE    = 16,
   parameter int EOI_TIMEOUT = 1024
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [NSRC-1:0] src_i,
   output logic [31:0]     irq_o,
   input  logic [31:0]     eoi_i,
   input  logic            reg_req_i,
   input  logic            reg_we_i,
   input  logic [3:0]      reg_addr_i,
   input  logic [31:0]     reg_wdata_i,
   output logic [31:0]     reg_rdata_o,
   output logic            reg_ack_o,
   output logic            timeout_o
);

   localparam int CW = $clog2(EOI_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_EOI, WAIT_LOW} state_t;

   state_t          state_q, state_d;
   logic [3:0]      id_q, id_d, win_id;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NSRC-1:0] src_q, enable_q, pending_q, pending_d;
   logic [NSRC-1:0] src_rise, req_en, w1c, force_set, grant_clr;
   logic [15:0]     eoi_src, irq_src;
   logic            grant, eoi_hit, wr_en;
   logic [1:0]      reg_sel;
   logic [31:0]     rdata_d, rdata_q;
   logic            ack_q;
   logic            unused_ok;

   assign unused_ok = ^{reg_addr_i[1:0], reg_wdata_i, eoi_i};

   assign wr_en     = reg_req_i & reg_we_i;
   assign reg_sel   = reg_addr_i[3:2];
   assign w1c       = (wr_en && reg_sel == 2'd1) ? reg_wdata_i[NSRC-1:0] : '0;
   assign force_set = (wr_en && reg_sel == 2'd3) ? reg_wdata_i[NSRC-1:0] : '0;
   assign src_rise  = src_i & ~src_q;
   assign req_en    = pending_q & enable_q;
   assign grant_clr = grant ? (NSRC'(1) << win_id) : '0;

   // Sets are OR-ed in last so an edge or FORCE beats a same-cycle clear.
   assign pending_d = (pending_q & ~w1c & ~grant_clr) | src_rise | force_set;

   always_comb begin
      eoi_src = '0;
      eoi_src[NSRC-1:0] = eoi_i[IRQ_BASE +: NSRC];
   end
   assign eoi_hit = eoi_src[id_q];

`ifdef IRQ_ARBITER_RR_EN
   logic [3:0]  last_q;
   logic [4:0]  rr_idx;
   logic [15:0] req_wide;

   // Walk the search order backwards so the earliest candidate is written last.
   always_comb begin
      win_id   = '0;
      rr_idx   = '0;
      req_wide = '0;
      req_wide[NSRC-1:0] = req_en;
      for (int i = NSRC-1; i >= 0; i--) begin
         rr_idx = {1'b0, last_q} + 5'd1 + 5'(i);
         if (rr_idx >= 5'(NSRC)) rr_idx = rr_idx - 5'(NSRC);
         if (req_wide[rr_idx[3:0]]) win_id = rr_idx[3:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)    last_q <= 4'(NSRC-1);
      else if (grant) last_q <= win_id;
   end
`else
   always_comb begin
      win_id = '0;
      for (int i = NSRC-1; i >= 0; i--) begin
         if (req_en[i]) win_id = 4'(i);
      end
   end
`endif

   always_comb begin
      state_d   = state_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      grant     = 1'b0;
      timeout_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req_en) begin
               grant   = 1'b1;
               id_d    = win_id;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_EOI;
         end
         WAIT_EOI: begin
            if (cnt_q == CW'(EOI_TIMEOUT-1)) begin
               timeout_o = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (eoi_hit) state_d = WAIT_LOW;
            end
         end
         WAIT_LOW: begin
            if (cnt_q == CW'(EOI_TIMEOUT-1)) begin
               timeout_o = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (!eoi_hit) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Decoded straight from flops so an asynchronous reset drops the pulse at once.
   always_comb begin
      irq_src = '0;
      irq_o   = '0;
      if (state_q == ISSUE) irq_src = 16'(1) << id_q;
      irq_o[IRQ_BASE +: NSRC] = irq_src[NSRC-1:0];
   end

   always_comb begin
      rdata_d = '0;
      case (reg_sel)
         2'd0:    rdata_d = 32'(enable_q);
         2'd1:    rdata_d = 32'(pending_q);
         2'd2:    rdata_d = {(state_q != IDLE), 27'd0, id_q};
         default: rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         id_q      <= '0;
         cnt_q     <= '0;
         src_q     <= '0;
         enable_q  <= '0;
         pending_q <= '0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         src_q     <= src_i;
         pending_q <= pending_d;
         ack_q     <= reg_req_i;
         rdata_q   <= (reg_req_i && !reg_we_i) ? rdata_d : '0;
         if (wr_en && reg_sel == 2'd0) enable_q <= reg_wdata_i[NSRC-1:0];
      end
   end

   assign reg_ack_o   = ack_q;
   assign reg_rdata_o = rdata_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: priority, masking, W1C/FORCE race, timeout, re-fire and reset.
module tb_irq_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [7:0]  src_i;
   logic [31:0] irq_o;
   logic [31:0] eoi_i;
   logic        reg_req_i;
   logic        reg_we_i;
   logic [3:0]  reg_addr_i;
   logic [31:0] reg_wdata_i;
   logic [31:0] reg_rdata_o;
   logic        reg_ack_o;
   logic        timeout_o;

   int errors = 0;
   int checks = 0;

   irq_arbiter dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .src_i       (src_i),
      .irq_o       (irq_o),
      .eoi_i       (eoi_i),
      .reg_req_i   (reg_req_i),
      .reg_we_i    (reg_we_i),
      .reg_addr_i  (reg_addr_i),
      .reg_wdata_i (reg_wdata_i),
      .reg_rdata_o (reg_rdata_o),
      .reg_ack_o   (reg_ack_o),
      .timeout_o   (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
      reg_req_i   = 1'b1;
      reg_we_i    = 1'b1;
      reg_addr_i  = addr;
      reg_wdata_i = data;
      tick();
      reg_req_i   = 1'b0;
      reg_we_i    = 1'b0;
      reg_wdata_i = '0;
   endtask

   task automatic reg_read(input logic [3:0] addr, input string tag, input logic [31:0] exp);
      reg_req_i  = 1'b1;
      reg_we_i   = 1'b0;
      reg_addr_i = addr;
      tick();
      reg_req_i  = 1'b0;
      check({tag, "_ack"}, {31'd0, reg_ack_o}, 32'd1);
      check(tag, reg_rdata_o, exp);
   endtask

   task automatic wait_irq(input string tag, input logic [31:0] exp, input int budget);
      int n = 0;
      while (irq_o == 0 && n < budget) begin
         tick();
         n++;
      end
      check(tag, irq_o, exp);
   endtask

   task automatic eoi_ack(input int bit_idx);
      eoi_i[bit_idx] = 1'b1;
      tick();
      tick();
      eoi_i = '0;
      tick();
   endtask

   initial begin
      logic        seen;
      logic [31:0] active;
      rst_ni      = 1'b0;
      src_i       = '0;
      eoi_i       = '0;
      reg_req_i   = 1'b0;
      reg_we_i    = 1'b0;
      reg_addr_i  = '0;
      reg_wdata_i = '0;

      // Reset values
      #12;
      check("rst_irq", irq_o, 32'h0);
      check("rst_rdata", reg_rdata_o, 32'h0);
      check("rst_ack", {31'd0, reg_ack_o}, 32'h0);
      check("rst_timeout", {31'd0, timeout_o}, 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      tick();
      reg_read(4'h0, "rst_enable", 32'h0);
      reg_read(4'h4, "rst_pending", 32'h0);
      reg_read(4'h8, "rst_active", 32'h0);
      tick();
      check("idle_rdata", reg_rdata_o, 32'h0);
      check("idle_ack", {31'd0, reg_ack_o}, 32'h0);

      // Fixed priority: src 2 before src 5
      reg_write(4'h0, 32'hFF);
      src_i = 8'h24;
      tick();
      src_i = '0;
      check("prio_not_yet", irq_o, 32'h0);
      wait_irq("prio_first", 32'h0004_0000, 4);
      eoi_ack(18);
      wait_irq("prio_second", 32'h0020_0000, 4);
      eoi_ack(21);
      reg_read(4'h4, "prio_pending", 32'h0);

      // Masked edge is captured but not issued
      reg_write(4'h0, 32'h00);
      src_i = 8'h08;
      tick();
      src_i = '0;
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (irq_o != 0) seen = 1'b1;
      end
      check("mask_no_irq", {31'd0, seen}, 32'h0);
      reg_read(4'h4, "mask_pending", 32'h08);
      reg_write(4'h0, 32'h08);
      check("mask_not_yet", irq_o, 32'h0);
      tick();
      check("mask_irq", irq_o, 32'h0008_0000);
      reg_read(4'h4, "mask_pending_clr", 32'h0);
      eoi_ack(19);

      // W1C racing a source edge, then FORCE
      reg_write(4'h0, 32'h00);
      reg_req_i   = 1'b1;
      reg_we_i    = 1'b1;
      reg_addr_i  = 4'h4;
      reg_wdata_i = 32'h01;
      src_i       = 8'h01;
      tick();
      reg_req_i   = 1'b0;
      reg_we_i    = 1'b0;
      reg_wdata_i = '0;
      src_i       = '0;
      reg_read(4'h4, "race_pending", 32'h01);
      reg_write(4'hC, 32'h80);
      reg_read(4'h4, "force_pending", 32'h81);
      reg_read(4'hC, "force_read", 32'h0);
      reg_write(4'h4, 32'hFF);
      reg_read(4'h4, "w1c_pending", 32'h0);

      // EOI timeout on src 1, then src 2 follows
      reg_write(4'hC, 32'h06);
      reg_write(4'h0, 32'h06);
      tick();
      check("to_issue", irq_o, 32'h0002_0000);
      seen = 1'b0;
      for (int i = 0; i < 1023; i++) begin
         tick();
         if (timeout_o) seen = 1'b1;
      end
      check("to_early", {31'd0, seen}, 32'h0);
      tick();
      check("to_pulse", {31'd0, timeout_o}, 32'h1);
      tick();
      check("to_single", {31'd0, timeout_o}, 32'h0);
      reg_req_i  = 1'b1;
      reg_we_i   = 1'b0;
      reg_addr_i = 4'h8;
      tick();
      reg_req_i  = 1'b0;
      active     = reg_rdata_o;
      check("to_active_idle", active & 32'h8000_0000, 32'h0);
      check("to_next", irq_o, 32'h0004_0000);
      eoi_ack(18);
      reg_read(4'h4, "to_pending", 32'h0);

      // Re-fire of the active source while waiting for eoi
      reg_write(4'h0, 32'h10);
      src_i = 8'h10;
      tick();
      src_i = '0;
      wait_irq("refire_first", 32'h0010_0000, 4);
      tick();
      reg_read(4'h8, "refire_active", 32'h8000_0004);
      src_i = 8'h10;
      tick();
      src_i = '0;
      seen = 1'b0;
      repeat (3) begin
         tick();
         if (irq_o != 0) seen = 1'b1;
      end
      check("refire_held", {31'd0, seen}, 32'h0);
      reg_read(4'h4, "refire_pending", 32'h10);
      eoi_ack(20);
      wait_irq("refire_second", 32'h0010_0000, 4);
      eoi_ack(20);
      reg_read(4'h4, "refire_pending_clr", 32'h0);

      // Reset while the pulse is on the bus
      reg_write(4'h0, 32'h01);
      reg_write(4'hC, 32'h01);
      wait_irq("rst_issue_pre", 32'h0001_0000, 4);
      #2;
      rst_ni = 1'b0;
      #1;
      check("rst_issue_irq", irq_o, 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      reg_read(4'h0, "rst_issue_enable", 32'h0);

      // Reset in WAIT_EOI
      reg_write(4'h0, 32'h01);
      reg_write(4'hC, 32'h01);
      wait_irq("rst_wait_pre", 32'h0001_0000, 4);
      tick();
      rst_ni = 1'b0;
      #1;
      check("rst_wait_irq", irq_o, 32'h0);
      check("rst_wait_timeout", {31'd0, timeout_o}, 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      reg_read(4'h0, "rst_wait_enable", 32'h0);
      reg_read(4'h4, "rst_wait_pending", 32'h0);
      reg_read(4'h8, "rst_wait_active", 32'h0);

      // After reset, source 0 has first priority, then source 1
      reg_write(4'h0, 32'hFF);
      src_i = 8'h03;
      tick();
      src_i = '0;
      wait_irq("post_rst_src0", 32'h0001_0000, 4);
      eoi_ack(16);
      wait_irq("post_rst_src1", 32'h0002_0000, 4);
      eoi_ack(17);
      reg_read(4'h4, "post_rst_pending", 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
